serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 clk  input  1  rising-edge clock; the block's single clock.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  WIDTH  first operand; sampled with start.
REQ-007 b  input  WIDTH  second operand; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse; result and flags are valid.
REQ-010 result  output  WIDTH  sum/difference; registered and held until the next accepted start.
REQ-011 cout  output  1  final carry out of the MSB; for subtract, 1 = no borrow.
REQ-012 overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-013 zero  output  1  high when result equals 0.

Function
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 IDLE with start=1 at an edge: load a into operand shift register A and (sub ? ~b : b) into B; set carry FF = sub; clear bit counter; go to RUN.
REQ-016 IDLE with start=0: remain in IDLE; all outputs hold their values.
REQ-017 RUN, each edge: add one bit, LSB-first, via full_adder on A[0], B[0] and the carry FF; shift the sum bit into result from the MSB side; shift A and B right; store carry-out in the carry FF; increment the counter.
REQ-018 On the RUN edge that processes bit WIDTH-1: latch cout from the final carry and overflow from carry-in(MSB) XOR carry-out(MSB); go to DONE.
REQ-019 Latency: done is high in the cycle following the WIDTH-th edge after the start-sampling edge (32 edges for WIDTH=32).
REQ-020 DONE: done=1 and busy=0 for exactly one cycle; the next edge returns the FSM to IDLE unconditionally.
REQ-021 start asserted in RUN or DONE is ignored, with no effect on operands, sub or the FSM.
REQ-022 result, cout and overflow do not change during RUN until the final edge; intermediate shift contents are not exposed on result.
REQ-023 zero is derived from the registered result and is valid whenever done=1 or the FSM is in IDLE.
REQ-024 Arithmetic is modulo 2^WIDTH; there is no saturation.
REQ-025 busy = (state == RUN); done = (state == DONE); both are glitch-free decodes of the state register.

Reset
REQ-026 While rst=1, asynchronously: state = IDLE, counter = 0, carry FF = 0, A = B = 0, result = 0, cout = 0, overflow = 0, busy = 0, done = 0; zero therefore reads 1.
REQ-027 rst asserted mid-RUN aborts the operation; no done pulse follows, and the first start after release begins a fresh operation.
REQ-028 The first edge after rst deasserts may accept start.

Structure
REQ-029 Shared package serial_adder_pkg holds the FSM state enum (IDLE, RUN, DONE) and the default-width constant.
REQ-030 Exactly one sub-module: the existing full_adder (ports a, b, cin, s, cout), instantiated once for the bit-slice.
REQ-031 The bit counter is $clog2(WIDTH) bits wide; no other arithmetic operators on data are used outside full_adder.

Verification
REQ-032 a=3, b=4, sub=0, start one cycle -> busy for 32 cycles, then done pulse with result=0x00000007, cout=0, overflow=0, zero=0.
REQ-033 a=5, b=7, sub=1 -> result=0xFFFFFFFE, cout=0, overflow=0, zero=0.
REQ-034 a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, overflow=1, cout=0; then a=0xFFFFFFFF, b=1 -> result=0, zero=1, cout=1, overflow=0.
REQ-035 start pulsed again at RUN cycle 10 with a=0xAAAAAAAA -> ignored; first result is unchanged; exactly one done pulse.
REQ-036 rst pulse at RUN cycle 16 -> all outputs at reset values immediately, no done pulse; a new start afterwards with a=9, b=9 gives result=18 after 32 edges.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial bit-slice.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single full adder.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | one operand bit per edge, WIDTH edges total
// DONE  | one-cycle done pulse, then back to IDLE
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sum_bit;
   logic             carry_out;
   logic             last_bit;

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (sum_bit),
      .cout (carry_out)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A doubles as the sum accumulator: sum bits enter at the MSB as operand bits leave at the LSB,
   // so result is only written once, on the final edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sr  <= {sum_bit, a_sr[WIDTH-1:1]};
               b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
               carry <= carry_out;
               cnt   <= cnt + CW'(1);
               if (last_bit) begin
                  result   <= {sum_bit, a_sr[WIDTH-1:1]};
                  cout     <= carry_out;
                  overflow <= carry ^ carry_out;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign zero = (result == '0);

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at the default 32-bit width.
module tb_serial_adder;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sub;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        cout;
   logic        overflow;
   logic        zero;

   int n_tests;
   int n_fail;

   serial_adder dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one operation and stop at the negedge where done is high (or after the bound).
   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         output int nbusy, output logic got);
      @(negedge clk);
      a = ia; b = ib; sub = isub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0;
      got   = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (done) got = 1'b1;
         else begin
            if (busy) nbusy++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      #3;
      n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_tests++; if (result !== 32'h0)  begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
      n_tests++; if (cout !== 1'b0)     begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
      n_tests++; if (zero !== 1'b1)     begin n_fail++; $display("FAIL reset_zero got %b want 1", zero); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add;
      int nb; logic got;
      run_op(32'd3, 32'd4, 1'b0, nb, got);
      n_tests++; if (got !== 1'b1)       begin n_fail++; $display("FAIL add_done got %b want 1", got); end
      n_tests++; if (nb != 32)           begin n_fail++; $display("FAIL add_latency got %0d want 32", nb); end
      n_tests++; if (result !== 32'h7)   begin n_fail++; $display("FAIL add_result got %h want 00000007", result); end
      n_tests++; if (cout !== 1'b0)      begin n_fail++; $display("FAIL add_cout got %b want 0", cout); end
      n_tests++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL add_ovf got %b want 0", overflow); end
      n_tests++; if (zero !== 1'b0)      begin n_fail++; $display("FAIL add_zero got %b want 0", zero); end
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL add_busy_in_done got %b want 0", busy); end
      @(negedge clk);
      n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL add_done_width got %b want 0", done); end
      n_tests++; if (result !== 32'h7)   begin n_fail++; $display("FAIL add_hold got %h want 00000007", result); end
   endtask

   task automatic test_sub;
      int nb; logic got;
      run_op(32'd5, 32'd7, 1'b1, nb, got);
      n_tests++; if (got !== 1'b1)             begin n_fail++; $display("FAIL sub_done got %b want 1", got); end
      n_tests++; if (result !== 32'hFFFFFFFE)  begin n_fail++; $display("FAIL sub_result got %h want fffffffe", result); end
      n_tests++; if (cout !== 1'b0)            begin n_fail++; $display("FAIL sub_cout got %b want 0", cout); end
      n_tests++; if (overflow !== 1'b0)        begin n_fail++; $display("FAIL sub_ovf got %b want 0", overflow); end
      n_tests++; if (zero !== 1'b0)            begin n_fail++; $display("FAIL sub_zero got %b want 0", zero); end
      run_op(32'd9, 32'd3, 1'b1, nb, got);
      n_tests++; if (result !== 32'h6)         begin n_fail++; $display("FAIL sub_noborrow_result got %h want 00000006", result); end
      n_tests++; if (cout !== 1'b1)            begin n_fail++; $display("FAIL sub_noborrow_cout got %b want 1", cout); end
      run_op(32'h80000000, 32'd1, 1'b1, nb, got);
      n_tests++; if (result !== 32'h7FFFFFFF)  begin n_fail++; $display("FAIL sub_ovf_result got %h want 7fffffff", result); end
      n_tests++; if (overflow !== 1'b1)        begin n_fail++; $display("FAIL sub_ovf_flag got %b want 1", overflow); end
   endtask

   task automatic test_overflow;
      int nb; logic got;
      run_op(32'h7FFFFFFF, 32'd1, 1'b0, nb, got);
      n_tests++; if (result !== 32'h80000000)  begin n_fail++; $display("FAIL ovf_result got %h want 80000000", result); end
      n_tests++; if (overflow !== 1'b1)        begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
      n_tests++; if (cout !== 1'b0)            begin n_fail++; $display("FAIL ovf_cout got %b want 0", cout); end
      run_op(32'hFFFFFFFF, 32'd1, 1'b0, nb, got);
      n_tests++; if (result !== 32'h0)         begin n_fail++; $display("FAIL wrap_result got %h want 00000000", result); end
      n_tests++; if (zero !== 1'b1)            begin n_fail++; $display("FAIL wrap_zero got %b want 1", zero); end
      n_tests++; if (cout !== 1'b1)            begin n_fail++; $display("FAIL wrap_cout got %b want 1", cout); end
      n_tests++; if (overflow !== 1'b0)        begin n_fail++; $display("FAIL wrap_ovf got %b want 0", overflow); end
   endtask

   task automatic test_ignore_start;
      int ndone; int cyc; logic seen_done;
      @(negedge clk);
      a = 32'h10; b = 32'h20; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0; cyc = 0; seen_done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         cyc++;
         if (cyc == 10) begin
            n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL run_hold got %h want 00000000", result); end
            a = 32'hAAAAAAAA; b = 32'h55555555; sub = 1'b1; start = 1'b1;
         end
         if (cyc == 11) start = 1'b0;
         if (done) begin
            ndone++;
            if (!seen_done) begin
               seen_done = 1'b1;
               n_tests++; if (result !== 32'h30) begin n_fail++; $display("FAIL ignore_result got %h want 00000030", result); end
               n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL ignore_latency got %0d want 33", cyc); end
               a = 32'h1; b = 32'h1; start = 1'b1;
               @(negedge clk);
               cyc++;
               start = 1'b0;
               n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored got busy %b want 0", busy); end
            end
         end
         @(negedge clk);
      end
      n_tests++; if (ndone != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
      n_tests++; if (result !== 32'h30) begin n_fail++; $display("FAIL ignore_final got %h want 00000030", result); end
   endtask

   task automatic test_rst_mid_run;
      int ndone; int nb; logic got;
      @(negedge clk);
      a = 32'h11; b = 32'h22; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got %b want 1", busy); end
      #2 rst = 1'b1;
      #1;
      n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
      n_tests++; if (result !== 32'h0)  begin n_fail++; $display("FAIL arst_result got %h want 00000000", result); end
      n_tests++; if (zero !== 1'b1)     begin n_fail++; $display("FAIL arst_zero got %b want 1", zero); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL arst_ovf got %b want 0", overflow); end
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      n_tests++; if (ndone != 0) begin n_fail++; $display("FAIL arst_no_done got %0d want 0", ndone); end
      run_op(32'd9, 32'd9, 1'b0, nb, got);
      n_tests++; if (got !== 1'b1)      begin n_fail++; $display("FAIL after_rst_done got %b want 1", got); end
      n_tests++; if (nb != 32)          begin n_fail++; $display("FAIL after_rst_latency got %0d want 32", nb); end
      n_tests++; if (result !== 32'd18) begin n_fail++; $display("FAIL after_rst_result got %h want 00000012", result); end
   endtask

   task automatic test_back_to_back;
      int nb; logic got;
      run_op(32'h12345678, 32'h11111111, 1'b0, nb, got);
      n_tests++; if (result !== 32'h23456789) begin n_fail++; $display("FAIL b2b1_result got %h want 23456789", result); end
      run_op(32'h0000FFFF, 32'h0000FFFF, 1'b1, nb, got);
      n_tests++; if (result !== 32'h0 || cout !== 1'b1) begin n_fail++; $display("FAIL b2b2_result got %h/%b want 00000000/1", result, cout); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_ignore_start();
      test_rst_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
